// File: rtl/board_init.sv
// board_init: Flood-It board generator; fills the board RAM with LFSR colours on request.
// Optional BOARD_INIT_RETRY_CAP_EN bounds rejection sampling to 8 candidates per cell.
module board_init #(
    parameter int unsigned MAX_SIZE = 26,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic              MASTER_CLOCK,
    input  logic              RESET_N,
    input  logic              INITIALIZE_BOARD,
    input  logic [4:0]        SIZE,
    input  logic [3:0]        COLOR_NUM,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [2:0]        WR_DATA,
    output logic              BOARD_READY,
    output logic              BUSY,
    output logic [2:0]        ORIGIN_COLOR
);

    localparam logic [15:0]       LfsrMask = 16'hB400;
    localparam logic [4:0]        MaxSize  = 5'(MAX_SIZE);
    localparam logic [ADDR_W-1:0] Stride   = ADDR_W'(MAX_SIZE);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_shift;
    logic [4:0]        size_q, size_d;
    logic [3:0]        ncol_q, ncol_d;
    logic [4:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [2:0]        origin_q, origin_d;
    logic [2:0]        cand, accept_data;
    logic              accept, last_col, last_row;
`ifdef BOARD_INIT_RETRY_CAP_EN
    logic [2:0]        rej_q, rej_d;
`endif

    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            lfsr_q     <= SEED;
            size_q     <= 5'd0;
            ncol_q     <= 4'd0;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            row_base_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 3'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            origin_q   <= 3'd0;
`ifdef BOARD_INIT_RETRY_CAP_EN
            rej_q      <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            size_q     <= size_d;
            ncol_q     <= ncol_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            origin_q   <= origin_d;
`ifdef BOARD_INIT_RETRY_CAP_EN
            rej_q      <= rej_d;
`endif
        end
    end

    // Galois step runs every cycle regardless of state so request timing adds entropy.
    always_comb begin
        lfsr_shift = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
        lfsr_d     = (lfsr_shift == 16'h0000) ? 16'h0001 : lfsr_shift;
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        ncol_d      = ncol_q;
        row_d       = row_q;
        col_d       = col_q;
        row_base_d  = row_base_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        origin_d    = origin_q;
        // Status outputs are registered copies of the state, one edge behind it.
        busy_d      = (state_q == StFill);
        ready_d     = (state_q == StDone);
        cand        = lfsr_q[2:0];
        accept      = 1'b0;
        accept_data = cand;
        last_col    = (col_q == size_q - 5'd1);
        last_row    = (row_q == size_q - 5'd1);
`ifdef BOARD_INIT_RETRY_CAP_EN
        rej_d       = rej_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (INITIALIZE_BOARD && !ready_q) begin
                    if (SIZE < 5'd2) begin
                        size_d = 5'd2;
                    end else if (SIZE > MaxSize) begin
                        size_d = MaxSize;
                    end else begin
                        size_d = SIZE;
                    end
                    if (COLOR_NUM < 4'd2) begin
                        ncol_d = 4'd2;
                    end else if (COLOR_NUM > 4'd8) begin
                        ncol_d = 4'd8;
                    end else begin
                        ncol_d = COLOR_NUM;
                    end
                    row_d      = 5'd0;
                    col_d      = 5'd0;
                    row_base_d = '0;
`ifdef BOARD_INIT_RETRY_CAP_EN
                    rej_d      = 3'd0;
`endif
                    state_d    = StFill;
                end
            end

            StFill: begin
                if (!INITIALIZE_BOARD) begin
                    state_d = StIdle;
                end else begin
                    if ({1'b0, cand} < ncol_q) begin
                        accept = 1'b1;
                    end
`ifdef BOARD_INIT_RETRY_CAP_EN
                    // Eighth candidate for a cell is forced legal; colour count is at least 2.
                    else if (rej_q == 3'd7) begin
                        accept      = 1'b1;
                        accept_data = cand & 3'b001;
                    end
`endif
                    if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base_q + ADDR_W'(col_q);
                        wr_data_d = accept_data;
                        if (row_q == 5'd0 && col_q == 5'd0) begin
                            origin_d = accept_data;
                        end
`ifdef BOARD_INIT_RETRY_CAP_EN
                        rej_d = 3'd0;
`endif
                        if (last_col) begin
                            col_d      = 5'd0;
                            row_d      = row_q + 5'd1;
                            row_base_d = row_base_q + Stride;
                            if (last_row) begin
                                state_d = StDone;
                            end
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else begin
`ifdef BOARD_INIT_RETRY_CAP_EN
                        rej_d = rej_q + 3'd1;
`endif
                    end
                end
            end

            StDone: begin
                if (!INITIALIZE_BOARD) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign WR_EN        = wr_en_q;
    assign WR_ADDR      = wr_addr_q;
    assign WR_DATA      = wr_data_q;
    assign BOARD_READY  = ready_q;
    assign BUSY         = busy_q;
    assign ORIGIN_COLOR = origin_q;

endmodule

// File: tb/tb_board_init.sv
// tb_board_init: randomized self-checking bench for board_init against a cell-by-cell
// rejection-sampling model driven by a free-running LFSR reference.
module tb_board_init;

    localparam int          MAX_SIZE = 26;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   = 1'b0;
    logic [4:0] size  = 5'd0;
    logic [3:0] cnum  = 4'd0;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [2:0] wr_data;
    logic       ready;
    logic       busy;
    logic [2:0] origin;

    board_init #(.MAX_SIZE(26), .ADDR_W(10), .SEED(SEED)) dut (
        .MASTER_CLOCK    (clk),
        .RESET_N         (rst_n),
        .INITIALIZE_BOARD(req),
        .SIZE            (size),
        .COLOR_NUM       (cnum),
        .WR_EN           (wr_en),
        .WR_ADDR         (wr_addr),
        .WR_DATA         (wr_data),
        .BOARD_READY     (ready),
        .BUSY            (busy),
        .ORIGIN_COLOR    (origin)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] lfsr_m;
    int got_addr[$], got_data[$], got_edge[$];
    int exp_addr[$], exp_data[$];
    int exp_rej;
    int k_edge;
    int saved_data[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        if (y == 16'h0000) y = 16'h0001;
        return y;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= lfsr_next(lfsr_m);

    always @(negedge clk)
        if (rst_n && wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            got_edge.push_back(cyc);
        end

    // Expected write list for a board filled from LFSR state 'start'; returns rejected cycles.
    function automatic int build_model(input logic [15:0] start, input int sz, input int cn);
        int n, c, rej, tries, cand;
        logic [15:0] l;
        bit done;
        n = (sz < 2) ? 2 : ((sz > MAX_SIZE) ? MAX_SIZE : sz);
        c = (cn < 2) ? 2 : ((cn > 8) ? 8 : cn);
        l = start;
        rej = 0;
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < n; r++) begin
            for (int col = 0; col < n; col++) begin
                tries = 0;
                done  = 1'b0;
                while (!done) begin
                    cand = int'(l[2:0]);
                    l = lfsr_next(l);
                    if (cand < c) begin
                        exp_addr.push_back(r * MAX_SIZE + col);
                        exp_data.push_back(cand);
                        done = 1'b1;
`ifdef BOARD_INIT_RETRY_CAP_EN
                    end else if (tries == 7) begin
                        exp_addr.push_back(r * MAX_SIZE + col);
                        exp_data.push_back(cand % 2);
                        done = 1'b1;
`endif
                    end else begin
                        tries++;
                        rej++;
                    end
                end
            end
        end
        return rej;
    endfunction

    function automatic int count_diffs(input int n);
        int d = 0;
        for (int i = 0; i < n; i++)
            if (i >= got_addr.size() || i >= exp_addr.size() ||
                got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) d++;
        return d;
    endfunction

    task automatic start_fill(input int sz, input int cn);
        @(negedge clk);
        got_addr.delete();
        got_data.delete();
        got_edge.delete();
        size = 5'(sz);
        cnum = 4'(cn);
        req  = 1'b1;
        @(posedge clk);
        #1;
        k_edge  = cyc;
        exp_rej = build_model(lfsr_m, sz, cn);
    endtask

    task automatic wait_ready(input int limit, output int seen);
        seen = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = cyc;
                break;
            end
        end
    endtask

    task automatic drop_req();
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        total++; if (wr_addr !== 10'd0) begin bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        total++; if (wr_data !== 3'd0) begin bad++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (origin !== 3'd0) begin bad++; $display("FAIL reset_origin: got %0d want 0", origin); end
        rst_n = 1'b1;
    endtask

    task automatic test_exact();
        int re, d, edge_err, addr_err;
        int want_addr[4];
        want_addr = '{0, 1, 26, 27};
        repeat (2) @(negedge clk);
        start_fill(2, 8);
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1 || wr_en !== 1'b1) begin bad++;
            $display("FAIL exact_first_write: busy=%b wr_en=%b want 1 1", busy, wr_en); end
        wait_ready(100, re);
        total++; if (re != k_edge + 5) begin bad++;
            $display("FAIL exact_ready_edge: got %0d want %0d", re - k_edge, 5); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL exact_busy_low: got %b want 0", busy); end
        total++; if (got_addr.size() != 4) begin bad++;
            $display("FAIL exact_count: got %0d want 4", got_addr.size()); end
        addr_err = 0;
        edge_err = 0;
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            if (got_addr[i] != want_addr[i]) addr_err++;
            if (got_edge[i] != k_edge + 1 + i) edge_err++;
        end
        total++; if (addr_err != 0) begin bad++; $display("FAIL exact_addr: got %0d wrong want 0", addr_err); end
        total++; if (edge_err != 0) begin bad++; $display("FAIL exact_timing: got %0d late want 0", edge_err); end
        d = count_diffs(4);
        total++; if (d != 0) begin bad++; $display("FAIL exact_data: got %0d diffs want 0", d); end
        total++; if (int'(origin) != exp_data[0]) begin bad++;
            $display("FAIL exact_origin: got %0d want %0d", origin, exp_data[0]); end
        saved_data = got_data;
        drop_req();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL exact_ready_fall: got %b want 0", ready); end
    endtask

    task automatic test_full();
        int re, d, over;
        repeat ($urandom_range(0, 20)) @(negedge clk);
        start_fill(26, 3);
        wait_ready(20000, re);
        total++; if (re != k_edge + 677 + exp_rej) begin bad++;
            $display("FAIL full_latency: got %0d want %0d", re - k_edge, 677 + exp_rej); end
        total++; if (got_addr.size() != 676) begin bad++;
            $display("FAIL full_count: got %0d want 676", got_addr.size()); end
        over = 0;
        foreach (got_data[i]) if (got_data[i] > 2) over++;
        total++; if (over != 0) begin bad++; $display("FAIL full_range: got %0d over 2 want 0", over); end
        d = count_diffs(676);
        total++; if (d != 0) begin bad++; $display("FAIL full_model: got %0d diffs want 0", d); end
        total++; if (int'(origin) != exp_data[0]) begin bad++;
            $display("FAIL full_origin: got %0d want %0d", origin, exp_data[0]); end
        drop_req();
    endtask

    task automatic test_clamp();
        int re, d, maxa, over;
        bit [7:0] seen;
        start_fill(31, 15);
        wait_ready(20000, re);
        maxa = 0;
        seen = '0;
        foreach (got_addr[i]) begin
            if (got_addr[i] > maxa) maxa = got_addr[i];
            seen[got_data[i]] = 1'b1;
        end
        total++; if (got_addr.size() != 676) begin bad++;
            $display("FAIL clamp_hi_count: got %0d want 676", got_addr.size()); end
        total++; if (maxa != 675) begin bad++; $display("FAIL clamp_hi_maxaddr: got %0d want 675", maxa); end
        total++; if (seen != 8'hFF) begin bad++; $display("FAIL clamp_hi_colours: got %h want ff", seen); end
        d = count_diffs(676);
        total++; if (d != 0) begin bad++; $display("FAIL clamp_hi_model: got %0d diffs want 0", d); end
        drop_req();
        start_fill(0, 1);
        wait_ready(2000, re);
        over = 0;
        foreach (got_data[i]) if (got_data[i] > 1) over++;
        total++; if (got_addr.size() != 4) begin bad++;
            $display("FAIL clamp_lo_count: got %0d want 4", got_addr.size()); end
        total++; if (over != 0) begin bad++; $display("FAIL clamp_lo_range: got %0d over 1 want 0", over); end
        d = count_diffs(4);
        total++; if (d != 0 || re != k_edge + 5 + exp_rej) begin bad++;
            $display("FAIL clamp_lo_model: got %0d diffs latency %0d want 0 %0d", d, re - k_edge,
                     5 + exp_rej); end
        drop_req();
    endtask

    task automatic test_random();
        int re, d, sz, cn;
        for (int it = 0; it < 5; it++) begin
            sz = $urandom_range(0, 12);
            cn = $urandom_range(0, 15);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            start_fill(sz, cn);
            wait_ready(10000, re);
            d = count_diffs(exp_addr.size());
            total++; if (d != 0 || got_addr.size() != exp_addr.size()) begin bad++;
                $display("FAIL random_model size=%0d col=%0d: got %0d writes %0d diffs want %0d 0",
                         sz, cn, got_addr.size(), d, exp_addr.size()); end
            total++; if (re != k_edge + exp_addr.size() + exp_rej + 1) begin bad++;
                $display("FAIL random_latency: got %0d want %0d", re - k_edge,
                         exp_addr.size() + exp_rej + 1); end
            drop_req();
        end
    endtask

    task automatic test_abort();
        int re, d, waited;
        bit rose;
        start_fill(10, 4);
        waited = 0;
        while (got_addr.size() < 10 && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        req  = 1'b0;
        rose = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ready) rose = 1'b1;
        end
        total++; if (got_addr.size() != 10) begin bad++;
            $display("FAIL abort_writes: got %0d want 10", got_addr.size()); end
        total++; if (rose) begin bad++; $display("FAIL abort_ready: got 1 want 0"); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        d = count_diffs(10);
        total++; if (d != 0) begin bad++; $display("FAIL abort_prefix: got %0d diffs want 0", d); end
        start_fill(2, 8);
        wait_ready(100, re);
        total++; if (got_addr.size() != 4 || re != k_edge + 5) begin bad++;
            $display("FAIL abort_restart: got %0d writes latency %0d want 4 5", got_addr.size(),
                     re - k_edge); end
        drop_req();
    endtask

    task automatic test_back_to_back();
        int re, n;
        start_fill(3, 5);
        wait_ready(1000, re);
        n = got_addr.size();
        repeat (20) @(negedge clk);
        total++; if (got_addr.size() != n || ready !== 1'b1) begin bad++;
            $display("FAIL hold_no_refill: got %0d writes ready %b want %0d 1", got_addr.size(),
                     ready, n); end
        drop_req();
        repeat (5) @(negedge clk);
        total++; if (got_addr.size() != n || busy !== 1'b0) begin bad++;
            $display("FAIL drop_no_refill: got %0d writes busy %b want %0d 0", got_addr.size(),
                     busy, n); end
        start_fill(3, 5);
        wait_ready(1000, re);
        total++; if (got_addr.size() != 9 || count_diffs(9) != 0) begin bad++;
            $display("FAIL rerequest_fill: got %0d writes want 9", got_addr.size()); end
        drop_req();
    endtask

    task automatic test_async_reset();
        int re, waited, d;
        start_fill(26, 8);
        waited = 0;
        while (got_addr.size() < 20 && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        total++; if ({wr_en, wr_addr, wr_data, ready, busy, origin} !== '0) begin bad++;
            $display("FAIL async_reset_outputs: got en=%b addr=%0d data=%0d rdy=%b busy=%b org=%0d want 0",
                     wr_en, wr_addr, wr_data, ready, busy, origin); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_fill(2, 8);
        wait_ready(100, re);
        d = 0;
        for (int i = 0; i < 4; i++)
            if (i >= got_data.size() || i >= saved_data.size() || got_data[i] != saved_data[i]) d++;
        total++; if (d != 0) begin bad++; $display("FAIL async_replay: got %0d diffs want 0", d); end
        drop_req();
    endtask

`ifdef BOARD_INIT_RETRY_CAP_EN
    task automatic test_retry_cap();
        int re, gap, worst, over;
        start_fill(26, 2);
        wait_ready(20000, re);
        worst = 0;
        over  = 0;
        foreach (got_edge[i]) begin
            gap = (i == 0) ? got_edge[i] - k_edge : got_edge[i] - got_edge[i-1];
            if (gap > worst) worst = gap;
            if (got_data[i] > 1) over++;
        end
        total++; if (got_addr.size() != 676 || worst > 8) begin bad++;
            $display("FAIL cap_gap: got %0d writes worst gap %0d want 676 <=8", got_addr.size(), worst); end
        total++; if (over != 0 || count_diffs(676) != 0) begin bad++;
            $display("FAIL cap_data: got %0d over 1 want 0", over); end
        drop_req();
    endtask
`endif

    initial begin
        test_reset();
        test_exact();
        test_full();
        test_clamp();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
`ifdef BOARD_INIT_RETRY_CAP_EN
        test_retry_cap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_init.md
# board_init

Board generator for the Flood-It game. Sits directly downstream of the game-setup selector: when the selector raises its initialize request, this block latches the chosen board size and colour count, then fills the board RAM with random colours row by row. A free-running LFSR supplies the colours. When the fill is complete it raises `BOARD_READY`, which the selector turns into `BEGIN_GAME`.

## Interface
- `MAX_SIZE`, 26: board RAM row stride and the largest legal `SIZE`.
- `ADDR_W`, 10: RAM address width; must satisfy 2^ADDR_W ≥ MAX_SIZE².
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `MASTER_CLOCK`  in  1  100 MHz system clock; all state is on its rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `INITIALIZE_BOARD`  in  1  level request from the selector; 4-phase request line.
- `SIZE`  in  5  board edge length; sampled only at start.
- `COLOR_NUM`  in  4  number of colours; sampled only at start.
- `WR_EN`  out  1  one-cycle RAM write strobe.
- `WR_ADDR`  out  ADDR_W  address, computed as row·MAX_SIZE + col.
- `WR_DATA`  out  3  colour index, always less than the latched colour count.
- `BOARD_READY`  out  1  fill complete; the 4-phase acknowledge.
- `BUSY`  out  1  high while in FILL.
- `ORIGIN_COLOR`  out  3  colour written to cell (0,0); this is the flood seed.

## Operation
- **Reset values:** all outputs are 0; the LFSR loads `SEED`; state is IDLE.
- **LFSR:** 16-bit Galois with mask 16'hB400. It shifts every cycle in every state, so user press timing adds entropy. If it ever holds 0 it is forced to 1.
- **Clamping at latch:**
  - SIZE below 2 becomes 2; SIZE above MAX_SIZE becomes MAX_SIZE.
  - COLOR_NUM below 2 becomes 2; COLOR_NUM above 8 becomes 8.
- **IDLE:** when `INITIALIZE_BOARD`=1 and `BOARD_READY`=0, latch the clamped values, zero `row`, `col` and `row_base`, then go to FILL.
- **FILL:** each cycle, `cand` = lfsr[2:0].
  - If `cand` < colour count, the cell is accepted: register WR_EN=1, WR_ADDR=row_base+col, WR_DATA=cand. If the cell is (0,0), also load `ORIGIN_COLOR`.
  - Advance `col`. At `col`=size−1, set `col`=0, increment `row`, and add MAX_SIZE to `row_base`. No multiplier is used.
  - If `cand` ≥ colour count, the cell is rejected: WR_EN=0 and the same cell is retried next cycle.
  - After the last cell (size−1, size−1) is accepted, go to DONE.
- **DONE:** `BOARD_READY`=1 and is held. When `INITIALIZE_BOARD`=0, clear `BOARD_READY` and return to IDLE.
- **Abort:** if `INITIALIZE_BOARD` falls during FILL, go to IDLE next edge. No further WR_EN; `BOARD_READY` stays 0; RAM contents are partial and undefined.
- **Re-request:** `INITIALIZE_BOARD` held high across DONE → IDLE does not restart a fill. A new fill requires the line to go low first.
- **`BUSY`** equals (state == FILL).

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Request sampled high at edge k:
  - FILL begins at edge k+1.
  - The first accepted cell drives WR_EN high after edge k+1.
- **With zero rejections:** writes are valid after edges k+1 … k+SIZE²; `BOARD_READY` rises after edge k+SIZE²+1.
- **Total fill latency:** SIZE² + (number of rejections) + 1 cycles.
- `BOARD_READY` falls one edge after `INITIALIZE_BOARD` is sampled low.
- **Reset mid-fill:** every output goes to 0 immediately (asynchronously); the LFSR returns to `SEED`.

## Configuration
- **`BOARD_INIT_RETRY_CAP_EN`:**
  - Defined: a 3-bit reject counter per cell. On the 8th consecutive candidate for one cell, that candidate is accepted with WR_DATA = cand & 3'b001. This is always legal because the colour count is at least 2. Worst case is 8 cycles per cell; the counter clears on every accept.
  - Undefined: pure rejection sampling with no counter. Latency is unbounded in principle but finite, because the LFSR is maximal-length.

## Test plan
- **Exact fill, no rejections:** SEED=16'hACE1, SIZE=2, COLOR_NUM=8, request at edge k → exactly 4 WR_EN pulses at addresses 0,1,26,27; `BOARD_READY` high after edge k+5; `BUSY` low from the same edge.
- **Full board, colour range:** SIZE=26, COLOR_NUM=3 → 676 writes to addresses {r·26+c}; every WR_DATA ≤ 2; WR_DATA and `ORIGIN_COLOR` match a bit-exact LFSR model; the cycle count equals 677 plus the model's rejection count.
- **Clamping:** SIZE=31, COLOR_NUM=15 → 676 writes, max address 675, WR_DATA covers 0–7. SIZE=0, COLOR_NUM=1 → 4 writes, every WR_DATA ∈ {0,1}.
- **Handshake and abort:** drop the request after 10 writes → no WR_EN afterwards, `BOARD_READY` never rises, state is IDLE. Hold the request high through DONE and then after the drop → no second fill until a new rising request.
- **Async reset:** assert RESET_N=0 mid-FILL → outputs read 0 before the next clock edge. After release, a repeat of the SIZE=2 case produces identical data.
- **Retry cap:** with `BOARD_INIT_RETRY_CAP_EN`, COLOR_NUM=2 over a 26×26 board → no cell takes more than 8 cycles between writes; every WR_DATA ≤ 1.
